// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and W variants
module div_unit #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic            word,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);
    localparam int H = XLEN / 2;
    localparam int CW = $clog2(XLEN + 1);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    function automatic logic [XLEN-1:0] fit(input logic w, input logic [XLEN-1:0] v);
        return w ? {{H{v[H-1]}}, v[H-1:0]} : v;
    endfunction

    logic [1:0]      state;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] quo, rem, dvs;
    logic            is_rem, is_word, neg_q, neg_r;

    logic            sgn, a_neg, b_neg, b_zero, ovf, ge;
    logic [XLEN-1:0] a_s, b_s, abs_a, abs_b, min_int, sp_sel;
    logic [XLEN:0]   shl, diff;
    logic [XLEN-1:0] rem_nx, quo_nx, q_fin, r_fin, fin;

    always_comb begin
        sgn     = ~op[0];
        a_s     = word ? {{H{sgn & src_a[H-1]}}, src_a[H-1:0]} : src_a;
        b_s     = word ? {{H{sgn & src_b[H-1]}}, src_b[H-1:0]} : src_b;
        a_neg   = sgn & a_s[XLEN-1];
        b_neg   = sgn & b_s[XLEN-1];
        abs_a   = a_neg ? -a_s : a_s;
        abs_b   = b_neg ? -b_s : b_s;
        min_int = word ? {{(H+1){1'b1}}, {(H-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
        b_zero  = b_s == '0;
        ovf     = sgn & (a_s == min_int) & (b_s == '1);
        sp_sel  = op[1] ? (b_zero ? a_s : '0) : (b_zero ? '1 : a_s);
        // one restoring step: shift in next dividend bit, subtract divisor if it fits
        shl     = {rem, quo[XLEN-1]};
        diff    = shl - {1'b0, dvs};
        ge      = ~diff[XLEN];
        rem_nx  = ge ? diff[XLEN-1:0] : shl[XLEN-1:0];
        quo_nx  = {quo[XLEN-2:0], ge};
        q_fin   = neg_q ? -quo_nx : quo_nx;
        r_fin   = neg_r ? -rem_nx : rem_nx;
        fin     = fit(is_word, is_rem ? r_fin : q_fin);
    end

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            result  <= '0;
            quo     <= '0;
            rem     <= '0;
            dvs     <= '0;
            is_rem  <= 1'b0;
            is_word <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    is_rem  <= op[1];
                    is_word <= word;
                    neg_q   <= a_neg ^ b_neg;
                    neg_r   <= a_neg;
                    dvs     <= abs_b;
                    quo     <= word ? abs_a << H : abs_a;
                    rem     <= '0;
                    if (b_zero | ovf) begin
                        result <= fit(word, sp_sel);
                        state  <= DONE;
                    end else begin
                        cnt   <= word ? CW'(H) : CW'(XLEN);
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    quo <= quo_nx;
                    rem <= rem_nx;
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        result <= fin;
                        state  <= DONE;
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed self-checking bench for div_unit
module tb_div_unit;
    logic        clk = 1'b0, reset = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0, word = 1'b0;
    logic        in_ready, out_valid;
    logic [1:0]  op = 2'd0;
    logic [63:0] src_a = '0, src_b = '0, result;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    div_unit #(.XLEN(64)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .word(word), .src_a(src_a), .src_b(src_b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input string tag, input logic [1:0] o, input logic w, input logic [63:0] a, input logic [63:0] b);
        int n = 0;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_rdy"}, 64'(in_ready), 64'd1);
        op = o; word = w; src_a = a; src_b = b; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        op = 2'($urandom); word = 1'($urandom);
        src_a = {$urandom, $urandom}; src_b = {$urandom, $urandom};
    endtask

    task automatic wait_valid(input string tag, input int lat_exp);
        int lat = 1;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'(lat_exp));
    endtask

    task automatic run(input string tag, input logic [1:0] o, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp, input int lat);
        issue(tag, o, w, a, b);
        wait_valid(tag, lat);
        check(tag, result, exp);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_hs"}, 64'({out_valid, in_ready}), 64'b01);
    endtask

    initial begin
        logic seen;
        tick();
        tick();
        check("reset", {62'd0, in_ready, out_valid}, 64'b10);
        check("reset_res", result, 64'd0);
        reset = 1'b0;
        tick();

        run("div_100_7",   2'b00, 1'b0, 64'd100, 64'd7, 64'd14, 65);
        run("rem_100_7",   2'b10, 1'b0, 64'd100, 64'd7, 64'd2, 65);
        run("rem_m7_2",    2'b10, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
        run("div_m7_2",    2'b00, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
        run("div_100_m7",  2'b00, 1'b0, 64'd100, -64'sd7, -64'sd14, 65);
        run("rem_100_m7",  2'b10, 1'b0, 64'd100, -64'sd7, 64'd2, 65);
        run("divu_5_0",    2'b01, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        run("remu_5_0",    2'b11, 1'b0, 64'd5, 64'd0, 64'd5, 1);
        run("div_ovf",     2'b00, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1);
        run("rem_ovf",     2'b10, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 1);
        run("divu_big",    2'b01, 1'b0, '1, 64'h10, 64'h0FFF_FFFF_FFFF_FFFF, 65);
        run("divw_ovf",    2'b00, 1'b1, 64'hFFFF_FFFF_8000_0000, '1, 64'hFFFF_FFFF_8000_0000, 1);
        run("divuw_a_2",   2'b01, 1'b1, 64'h1_0000_000A, 64'd2, 64'd5, 33);
        run("divuw_sext",  2'b01, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 33);
        run("remw_m7_2",   2'b10, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33);
        run("remuw_b0",    2'b11, 1'b1, 64'h7_8000_0000, 64'h1_0000_0000, 64'hFFFF_FFFF_8000_0000, 1);

        issue("bp", 2'b00, 1'b0, 64'd50, 64'd5);
        wait_valid("bp", 65);
        for (int i = 0; i < 10; i++) begin
            check("bp_res", result, 64'd10);
            check("bp_flags", 64'({out_valid, in_ready}), 64'b10);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release", 64'({out_valid, in_ready}), 64'b01);

        issue("flush", 2'b00, 1'b0, 64'd100, 64'd7);
        repeat (19) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_idle", 64'({out_valid, in_ready}), 64'b01);
        seen = 1'b0;
        for (int i = 0; i < 70; i++) begin
            seen |= out_valid;
            tick();
        end
        check("flush_noval", 64'(seen), 64'd0);
        check("flush_res", result, 64'd10);

        flush = 1'b1; in_valid = 1'b1; op = 2'b00; word = 1'b0; src_a = 64'd9; src_b = 64'd0;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_req", 64'({out_valid, in_ready}), 64'b01);
        seen = 1'b0;
        for (int i = 0; i < 70; i++) begin
            seen |= out_valid;
            tick();
        end
        check("flush_req_noval", 64'(seen), 64'd0);

        issue("rst_mid", 2'b00, 1'b0, 64'd100, 64'd7);
        repeat (10) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_mid_flags", 64'({out_valid, in_ready}), 64'b01);
        check("rst_mid_res", result, 64'd0);
        run("div_9_3", 2'b00, 1'b0, 64'd9, 64'd3, 64'd3, 65);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
